// File: rtl/score_bcd_counter.sv
// Packed-BCD game score keeper with best-score tracking.
// Feeds one 4-bit digit per 7-segment decoder, no binary conversion.
module score_bcd_counter #(
   parameter int DIGITS   = 3,
   parameter bit SATURATE = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  pass,
   input  logic                  game_over,
   output logic [4*DIGITS-1:0]   score_bcd,
   output logic [4*DIGITS-1:0]   best_bcd,
   output logic                  new_best,
   output logic                  overflow,
   output logic                  playing
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   score_q, score_d;
   logic [W-1:0]   best_q, best_d;
   logic           new_best_q, new_best_d;
   logic           overflow_q, overflow_d;
   logic           pass_q, pass_d;

   logic           inc;
   logic [W-1:0]   score_inc;
   logic           all_nines;
   logic           carry;

   // Ripple-carry BCD increment; carry out of the top digit means all-nines
   always_comb begin
      carry     = 1'b1;
      score_inc = score_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (score_q[4*i +: 4] == 4'd9) begin
               score_inc[4*i +: 4] = 4'd0;
            end else begin
               score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      all_nines = carry;
   end

   // Rising-edge detect on pass, only counted while playing
   assign inc = pass & ~pass_q & (state_q == PLAY);

   // Next-state and datapath: start beats game_over beats inc
   always_comb begin
      state_d    = state_q;
      score_d    = score_q;
      best_d     = best_q;
      new_best_d = new_best_q;
      overflow_d = overflow_q;
      pass_d     = pass;
      if (start) begin
         state_d    = PLAY;
         score_d    = '0;
         overflow_d = 1'b0;
         new_best_d = 1'b0;
      end else if (state_q == PLAY && game_over) begin
         state_d = OVER;
         // Packed BCD orders the same as its unsigned value
         if (score_q > best_q) begin
            best_d     = score_q;
            new_best_d = 1'b1;
         end
      end else if (inc) begin
         if (all_nines) begin
            overflow_d = 1'b1;
            score_d    = SATURATE ? score_q : '0;
         end else begin
            score_d = score_inc;
         end
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         score_q    <= '0;
         best_q     <= '0;
         new_best_q <= 1'b0;
         overflow_q <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         score_q    <= score_d;
         best_q     <= best_d;
         new_best_q <= new_best_d;
         overflow_q <= overflow_d;
         pass_q     <= pass_d;
      end
   end

   assign score_bcd = score_q;
   assign best_bcd  = best_q;
   assign new_best  = new_best_q;
   assign overflow  = overflow_q;
   assign playing   = (state_q == PLAY);

endmodule
